// File: rtl/fb_pkg.sv
// Shared defaults and types for the ping-pong scan-out framebuffer.
package fb_pkg;

    // Default framebuffer geometry and screen replication factors.
    localparam int FB_W_DEFAULT    = 20;
    localparam int FB_H_DEFAULT    = 20;
    localparam int SCALE_X_DEFAULT = 32;
    localparam int SCALE_Y_DEFAULT = 24;

    // Coordinate widths for the default geometry.
    localparam int XW = $clog2(FB_W_DEFAULT);
    localparam int YW = $clog2(FB_H_DEFAULT);

    // Back-bank clear machine.
    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/fb_bank.sv
// One H x W bit framebuffer bank: single-bit write, whole-row clear,
// combinational single-bit read.
module fb_bank #(
    parameter int W = 20,
    parameter int H = 20
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [$clog2(W)-1:0] wr_x,
    input  logic [$clog2(H)-1:0] wr_y,
    input  logic                 wr_data,
    input  logic                 clr_en,
    input  logic [$clog2(H)-1:0] clr_row,
    input  logic [$clog2(W)-1:0] rd_x,
    input  logic [$clog2(H)-1:0] rd_y,
    output logic                 rd_data
);

    logic [W-1:0] mem [H];

    // Row clear takes priority over a pixel write; the owner never issues both.
    // NOTE: the array has no reset term; clearing is done by the row-clear port,
    // which keeps this mappable onto plain registers/RAM without a reset tree.
    // NOTE: state updates use non-blocking assignments so every register samples
    // pre-edge values, whatever the order of statements.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_row] <= '0;
        end else if (wr_en) begin
            mem[wr_y][wr_x] <= wr_data;
        end
    end

    assign rd_data = mem[rd_y][rd_x];

endmodule

// File: rtl/fb_scanout.sv
// Ping-pong 1-bit framebuffer: writer fills the back bank, the VGA side
// scans the front bank with SCALE_X x SCALE_Y pixel replication, and bank
// swaps only happen at frame start.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int FB_W    = FB_W_DEFAULT,
    parameter int FB_H    = FB_H_DEFAULT,
    parameter int SCALE_X = SCALE_X_DEFAULT,
    parameter int SCALE_Y = SCALE_Y_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [$clog2(FB_W)-1:0] wr_x,
    input  logic [$clog2(FB_H)-1:0] wr_y,
    input  logic                    wr_data,
    input  logic                    clr_req,
    input  logic                    swap_req,
    output logic                    clr_busy,
    output logic                    swap_pending,
    output logic                    swap_done,
    input  logic                    frame_start,
    input  logic                    pix_req,
    output logic                    pixel_color,
    output logic                    pixel_valid
);

    localparam int XB  = $clog2(FB_W);
    localparam int YB  = $clog2(FB_H);
    localparam int FYB = $clog2(FB_H + 1);   // fb_y must be able to hold FB_H
    localparam int SXB = $clog2(SCALE_X);
    localparam int SYB = $clog2(SCALE_Y);

    localparam logic [SXB-1:0] SX_LAST  = SXB'(SCALE_X - 1);
    localparam logic [SYB-1:0] SY_LAST  = SYB'(SCALE_Y - 1);
    localparam logic [XB-1:0]  X_LAST   = XB'(FB_W - 1);
    localparam logic [YB-1:0]  ROW_LAST = YB'(FB_H - 1);
    localparam logic [FYB-1:0] Y_END    = FYB'(FB_H);
    localparam logic [XB:0]    X_LIM    = (XB + 1)'(FB_W);
    localparam logic [YB:0]    Y_LIM    = (YB + 1)'(FB_H);

    // ---------------- clear FSM ----------------
    clr_state_t      clr_state, clr_state_next;
    logic [YB-1:0]   clr_row, clr_row_next;
    logic            clr_all;   // post-reset clear covers both banks

    // Clear state register; reset lands in CLEAR so both banks get zeroed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_state <= CLR_CLEAR;
            clr_row   <= '0;
            clr_all   <= 1'b1;
        end else begin
            clr_state <= clr_state_next;
            clr_row   <= clr_row_next;
            if (clr_state == CLR_CLEAR && clr_row == ROW_LAST) begin
                clr_all <= 1'b0;
            end
        end
    end

    // Next-state: one row per cycle, clr_req only honoured while idle.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        clr_state_next = clr_state;
        clr_row_next   = clr_row;
        case (clr_state)
            CLR_IDLE: begin
                if (clr_req) begin
                    clr_state_next = CLR_CLEAR;
                    clr_row_next   = '0;
                end
            end
            CLR_CLEAR: begin
                if (clr_row == ROW_LAST) begin
                    clr_state_next = CLR_IDLE;
                    clr_row_next   = '0;
                end else begin
                    clr_row_next = clr_row + 1'b1;
                end
            end
            default: clr_state_next = CLR_IDLE;
        endcase
    end

    assign clr_busy = (clr_state == CLR_CLEAR);

    // ---------------- swap logic ----------------
    logic front_sel;
    logic do_swap;

    // A request arriving with frame_start counts as already pending.
    assign do_swap = frame_start && (swap_pending || swap_req) && !clr_busy;

    // Front-bank select, pending flag and the delayed done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            swap_done    <= do_swap;
            swap_pending <= do_swap ? 1'b0 : (swap_pending || swap_req);
            if (do_swap) begin
                front_sel <= ~front_sel;
            end
        end
    end

    // ---------------- write / clear routing ----------------
    logic wr_ok;
    logic front_now;   // front bank as seen by this cycle's read

    assign wr_ok = wr_en && !clr_busy && !clr_req
                   && ({1'b0, wr_x} < X_LIM) && ({1'b0, wr_y} < Y_LIM);
    assign front_now = front_sel ^ do_swap;

    // ---------------- scan counters ----------------
    logic [SXB-1:0] sub_x, sub_x_cur, sub_x_next;
    logic [SYB-1:0] sub_y, sub_y_cur, sub_y_next;
    logic [XB-1:0]  fb_x,  fb_x_cur,  fb_x_next;
    logic [FYB-1:0] fb_y,  fb_y_cur,  fb_y_next;
    logic           in_frame;
    logic [YB-1:0]  rd_y;

    // Effective counters (frame_start zeroes them first) and their advance.
    always_comb begin
        sub_x_cur  = frame_start ? '0 : sub_x;
        sub_y_cur  = frame_start ? '0 : sub_y;
        fb_x_cur   = frame_start ? '0 : fb_x;
        fb_y_cur   = frame_start ? '0 : fb_y;
        in_frame   = (fb_y_cur < Y_END);
        sub_x_next = sub_x_cur;
        sub_y_next = sub_y_cur;
        fb_x_next  = fb_x_cur;
        fb_y_next  = fb_y_cur;
        if (pix_req && in_frame) begin
            if (sub_x_cur == SX_LAST) begin
                sub_x_next = '0;
                if (fb_x_cur == X_LAST) begin
                    fb_x_next = '0;
                    if (sub_y_cur == SY_LAST) begin
                        sub_y_next = '0;
                        fb_y_next  = fb_y_cur + 1'b1;
                    end else begin
                        sub_y_next = sub_y_cur + 1'b1;
                    end
                end else begin
                    fb_x_next = fb_x_cur + 1'b1;
                end
            end else begin
                sub_x_next = sub_x_cur + 1'b1;
            end
        end
    end

    // Scan position registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_x <= '0;
            sub_y <= '0;
            fb_x  <= '0;
            fb_y  <= '0;
        end else begin
            sub_x <= sub_x_next;
            sub_y <= sub_y_next;
            fb_x  <= fb_x_next;
            fb_y  <= fb_y_next;
        end
    end

    // Past the last row the row index is parked at 0; the output is gated anyway.
    assign rd_y = in_frame ? fb_y_cur[YB-1:0] : '0;

    // ---------------- banks ----------------
    logic rd0, rd1;

    fb_bank #(.W(FB_W), .H(FB_H)) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_ok && front_sel),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .wr_data (wr_data),
        .clr_en  (clr_busy && (clr_all || front_sel)),
        .clr_row (clr_row),
        .rd_x    (fb_x_cur),
        .rd_y    (rd_y),
        .rd_data (rd0)
    );

    fb_bank #(.W(FB_W), .H(FB_H)) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_ok && !front_sel),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .wr_data (wr_data),
        .clr_en  (clr_busy && (clr_all || !front_sel)),
        .clr_row (clr_row),
        .rd_x    (fb_x_cur),
        .rd_y    (rd_y),
        .rd_data (rd1)
    );

    // Registered pixel output, one cycle behind the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_valid <= 1'b0;
            pixel_color <= 1'b0;
        end else begin
            pixel_valid <= pix_req;
            pixel_color <= pix_req && in_frame && (front_now ? rd1 : rd0);
        end
    end

endmodule
